ysyx_23060187_exu_md: RTL and testbench
=======================================

YSYX_23060187_EXU_MD -- requirements
Module: ysyx_23060187_exu_md

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath width (supported values 32 and 64).
REQ-002 SHALL have parameter RADDR_W, default 5: destination register index width.
REQ-003 SHALL have parameter CNT_W, default $clog2(XLEN)+1: iteration counter width.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  upstream operation valid.
REQ-007 SHALL have port in_ready  output  1  block can accept an operation.
REQ-008 SHALL have port in_md_en  input  1  1 = multiply/divide op; 0 = ALU pass-through.
REQ-009 SHALL have port in_md_op  input  3  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU = 0..7.
REQ-010 SHALL have port in_src1 / in_src2  input  XLEN  operands.
REQ-011 SHALL have port in_alu_result  input  XLEN  precomputed ALU result, used when in_md_en=0.
REQ-012 SHALL have port in_rd  input  RADDR_W  destination index; in_wen  input  1  register write enable.
REQ-013 SHALL have port flush  input  1  synchronous abort of any in-flight op.
REQ-014 SHALL have port out_valid  output  1  result valid to writeback.
REQ-015 SHALL have port out_ready  input  1  writeback accepts result.
REQ-016 SHALL have port out_result  output  XLEN; out_rd  output  RADDR_W; out_wen  output  1.
REQ-017 SHALL have port busy  output  1  high while in BUSY state.

Function
REQ-018 SHALL implement states IDLE, BUSY, DONE; in_ready = (state==IDLE) || (state==DONE && out_ready).
REQ-019 SHALL accept on in_valid && in_ready, latching operands, op, rd and wen.
REQ-020 Accepted op with in_md_en=0 SHALL go to DONE next cycle with out_result = in_alu_result (latency 1).
REQ-021 Accepted MUL-class op SHALL iterate in BUSY for exactly XLEN cycles (radix-2 shift-add on operand magnitudes, sign-corrected at the end), then enter DONE.
REQ-022 MUL SHALL return product[XLEN-1:0]; MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned SHALL return product[2*XLEN-1:XLEN].
REQ-023 Accepted DIV-class op SHALL iterate XLEN cycles as a restoring divider on magnitudes; quotient sign = sign1 XOR sign2, remainder sign = sign of src1 (signed ops only).
REQ-024 Divide by zero SHALL bypass iteration (DONE next cycle): quotient all-ones, remainder = src1.
REQ-025 Signed overflow (src1 = most-negative, src2 = -1) SHALL bypass iteration: quotient = src1, remainder = 0.
REQ-026 DONE SHALL hold out_valid=1 and stable outputs until out_ready; on handshake -> IDLE, or directly to a new op's state if a simultaneous accept occurs (back-to-back, no bubble).
REQ-027 out_valid SHALL be 1 only in DONE; busy SHALL be 1 only in BUSY; in_ready SHALL be 0 in BUSY.
REQ-028 flush SHALL, in any state, force IDLE and out_valid=0 next edge, discarding the op; flush has priority over accept and output handshake.
REQ-029 Iteration counter SHALL count XLEN-1 down to 0; BUSY->DONE transition when counter reaches 0.

Reset
REQ-030 On rst low (asynchronous): state=IDLE, out_valid=0, busy=0, out_result=0, out_rd=0, out_wen=0, counter=0, all operand/partial registers 0.
REQ-031 Reset asserted mid-iteration SHALL abandon the op; no result is ever presented for it.
REQ-032 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-033 Shared package SHALL hold the md_op encoding (8 constants), state encoding, and div-by-zero/overflow result constants.
REQ-034 The iterative multiply/divide datapath SHALL be a sub-module ysyx_23060187_md_iter (start, op, operands -> done, result); the FSM and handshake stay in the top.

Verification
REQ-035 ALU pass-through: in_md_en=0, in_alu_result=0x1234, rd=5, out_ready=1 -> out_valid one cycle later, out_result=0x1234, out_rd=5.
REQ-036 MULH, XLEN=32: src1=0xFFFFFFFF (-1), src2=0x00000002 -> after 32 BUSY cycles out_result=0xFFFFFFFF; MULHU same operands -> 0x00000001.
REQ-037 DIV by zero: src1=0x00000007, src2=0 -> DONE next cycle, DIV=0xFFFFFFFF, REM=0x00000007; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-038 Signed DIV/REM: src1=-7 (0xFFFFFFF9), src2=2 -> DIV=0xFFFFFFFD (-3), REM=0xFFFFFFFF (-1).
REQ-039 Backpressure/back-to-back: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0; raise out_ready with in_valid=1 -> new op accepted same cycle, no bubble.
REQ-040 flush at BUSY cycle 10 of a DIV, and rst pulse mid-MUL -> IDLE next edge, out_valid never asserted for the aborted op, next op completes correctly.

Source files
------------

// File: rtl/ysyx_23060187_exu_md_pkg.sv
// Shared encodings for the multiply/divide execute unit: op codes, FSM states
// and the fixed results of the divide special cases.
package ysyx_23060187_exu_md_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  // Sliced down to XLEN by the users; wide enough for XLEN=64.
  localparam logic [63:0] DIV0_QUOTIENT = '1;
  localparam logic [63:0] OVF_REMAINDER = '0;

  function automatic logic is_div_op(md_op_e op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic is_rem_op(md_op_e op);
    return op inside {MD_REM, MD_REMU};
  endfunction

endpackage

// File: rtl/ysyx_23060187_md_iter.sv
// Iterative radix-2 multiplier / restoring divider working on operand
// magnitudes, with sign fix-up on the final step and divide special cases.
module ysyx_23060187_md_iter
  import ysyx_23060187_exu_md_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            bypass,
  output logic [XLEN-1:0] bypass_result,
  output logic            done,
  output logic [XLEN-1:0] result
);

  md_op_e            op_e, op_r;
  logic              s1_signed, s2_signed, neg1, neg2, div_zero, div_ovf;
  logic [XLEN-1:0]   mag1, mag2;
  logic              active, neg_r;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   hi, lo, dsr, hi_n, lo_n, div_diff, div_val;
  logic [XLEN:0]     mul_sum, div_sh;
  logic              div_ge;
  logic [2*XLEN-1:0] prod, prod_fix;

  // Operand decode at start time.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    op_e          = md_op_e'(op);
    s1_signed     = op_e inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    s2_signed     = op_e inside {MD_MULH, MD_DIV, MD_REM};
    neg1          = s1_signed & src1[XLEN-1];
    neg2          = s2_signed & src2[XLEN-1];
    mag1          = neg1 ? -src1 : src1;
    mag2          = neg2 ? -src2 : src2;
    div_zero      = (src2 == '0);
    div_ovf       = s2_signed && (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);
    bypass        = is_div_op(op_e) && (div_zero || div_ovf);
    bypass_result = src1;
    if (div_zero)
      bypass_result = is_rem_op(op_e) ? src1 : DIV0_QUOTIENT[XLEN-1:0];
    else if (div_ovf)
      bypass_result = is_rem_op(op_e) ? OVF_REMAINDER[XLEN-1:0] : src1;
  end

  // One iteration step; the final result is taken from the last step directly.
  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, dsr} : '0);
    div_sh   = {hi, lo[XLEN-1]};
    div_ge   = (div_sh >= {1'b0, dsr});
    div_diff = div_sh[XLEN-1:0] - dsr;
    if (is_div_op(op_r)) begin
      hi_n = div_ge ? div_diff : div_sh[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], div_ge};
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo[XLEN-1:1]};
    end
    prod     = {hi_n, lo_n};
    prod_fix = neg_r ? -prod : prod;
    div_val  = is_rem_op(op_r) ? hi_n : lo_n;
    if (neg_r) div_val = -div_val;
    if (is_div_op(op_r))     result = div_val;
    else if (op_r == MD_MUL) result = prod_fix[XLEN-1:0];
    else                     result = prod_fix[2*XLEN-1:XLEN];
  end

  assign done = active && (cnt == '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active <= 1'b0;
      cnt    <= '0;
      op_r   <= MD_MUL;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      dsr    <= '0;
    end else if (kill) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start && !bypass) begin
      active <= 1'b1;
      cnt    <= CNT_W'(XLEN - 1);
      op_r   <= op_e;
      // Remainder follows the dividend sign; everything else uses sign1 ^ sign2.
      neg_r  <= is_rem_op(op_e) ? neg1 : (neg1 ^ neg2);
      hi     <= '0;
      lo     <= is_div_op(op_e) ? mag1 : mag2;
      dsr    <= is_div_op(op_e) ? mag2 : mag1;
    end else if (active) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt - CNT_W'(1);
      if (cnt == '0) active <= 1'b0;
    end
  end

endmodule

// File: rtl/ysyx_23060187_exu_md.sv
// Execute-stage multiply/divide unit: IDLE/BUSY/DONE handshake FSM around the
// iterative datapath, with ALU pass-through and flush.
module ysyx_23060187_exu_md
  import ysyx_23060187_exu_md_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = $clog2(XLEN) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_md_en,
  input  logic [2:0]         in_md_op,
  input  logic [XLEN-1:0]    in_src1,
  input  logic [XLEN-1:0]    in_src2,
  input  logic [XLEN-1:0]    in_alu_result,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_wen,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_result,
  output logic [RADDR_W-1:0] out_rd,
  output logic               out_wen,
  output logic               busy
);

  md_state_e       state, next_state;
  logic            accept, iter_bypass, iter_done;
  logic [XLEN-1:0] iter_bypass_result, iter_result;

  assign in_ready  = (state == ST_IDLE) || (state == ST_DONE && out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_BUSY);

  ysyx_23060187_md_iter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_iter (
    .clk           (clk),
    .rst           (rst),
    .start         (accept && in_md_en),
    .kill          (flush),
    .op            (in_md_op),
    .src1          (in_src1),
    .src2          (in_src2),
    .bypass        (iter_bypass),
    .bypass_result (iter_bypass_result),
    .done          (iter_done),
    .result        (iter_result)
  );

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept)
          next_state = (in_md_en && !iter_bypass) ? ST_BUSY : ST_DONE;
        else if (state == ST_DONE && out_ready)
          next_state = ST_IDLE;
      end
      ST_BUSY: if (iter_done) next_state = ST_DONE;
      default: next_state = ST_IDLE;
    endcase
    if (flush) next_state = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  // rd/wen are captured at accept; out_valid stays low until DONE, so early capture is invisible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_result <= '0;
      out_rd     <= '0;
      out_wen    <= 1'b0;
    end else if (accept) begin
      out_rd  <= in_rd;
      out_wen <= in_wen;
      if (!in_md_en)        out_result <= in_alu_result;
      else if (iter_bypass) out_result <= iter_bypass_result;
    end else if (state == ST_BUSY && iter_done && !flush) begin
      out_result <= iter_result;
    end
  end

endmodule

// File: tb/tb_ysyx_23060187_exu_md.sv
// Self-checking bench for ysyx_23060187_exu_md: directed cases plus random ops
// compared against an arithmetic reference model.
module tb_ysyx_23060187_exu_md;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, in_ready, in_md_en, in_wen, flush;
  logic [2:0]         in_md_op;
  logic [XLEN-1:0]    in_src1, in_src2, in_alu_result;
  logic [RADDR_W-1:0] in_rd;
  logic               out_valid, out_ready, out_wen, busy;
  logic [XLEN-1:0]    out_result;
  logic [RADDR_W-1:0] out_rd;

  int n_cmp = 0;
  int n_bad = 0;

  ysyx_23060187_exu_md #(.XLEN(XLEN), .RADDR_W(RADDR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_md_en      (in_md_en),
    .in_md_op      (in_md_op),
    .in_src1       (in_src1),
    .in_src2       (in_src2),
    .in_alu_result (in_alu_result),
    .in_rd         (in_rd),
    .in_wen        (in_wen),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_rd        (out_rd),
    .out_wen       (out_wen),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: full-width arithmetic straight from the RISC-V M rules.
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    logic signed [31:0] x, y;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    x   = a;
    y   = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 64'sd0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(x / y);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(x % y);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return 32'h0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input logic en, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] alu,
                       input logic [4:0] rd, input logic wen);
    in_valid      = 1'b1;
    in_md_en      = en;
    in_md_op      = op;
    in_src1       = a;
    in_src2       = b;
    in_alu_result = alu;
    in_rd         = rd;
    in_wen        = wen;
  endtask

  // Issues one op at a negedge with out_ready=1, checks latency, busy time and result.
  task automatic run_op(input string tag, input logic en, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] alu,
                        input logic [4:0] rd, input logic wen);
    logic [31:0] exp;
    int exp_wait, waited, busy_cnt, rdy_busy, guard;
    exp      = en ? ref_md(op, a, b) : alu;
    exp_wait = (!en || (op[2] && (b == 0 ||
               (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))) ? 0 : XLEN;
    out_ready = 1'b1;
    drive(en, op, a, b, alu, rd, wen);
    guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    check({tag, "/in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    waited = 0; busy_cnt = 0; rdy_busy = 0;
    while (!out_valid && waited < XLEN + 10) begin
      if (busy) busy_cnt++;
      if (busy && in_ready) rdy_busy++;
      @(negedge clk);
      waited++;
    end
    check({tag, "/latency"},  64'(waited),     64'(exp_wait));
    check({tag, "/busy_cyc"}, 64'(busy_cnt),   64'(exp_wait));
    check({tag, "/rdy_busy"}, 64'(rdy_busy),   64'd0);
    check({tag, "/result"},   64'(out_result), 64'(exp));
    check({tag, "/rd"},       64'(out_rd),     64'(rd));
    check({tag, "/wen"},      64'(out_wen),    64'(wen));
    @(negedge clk);
    check({tag, "/released"}, 64'(out_valid),  64'd0);
  endtask

  task automatic watch_no_valid(input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check({tag, "/no_valid"}, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [31:0] hold_exp;
    int guard;
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_md_en = 1'b0; in_md_op = 3'd0; in_src1 = '0; in_src2 = '0;
    in_alu_result = '0; in_rd = '0; in_wen = 1'b0;
    repeat (3) @(negedge clk);
    check("reset/out_valid", 64'(out_valid), 64'd0);
    check("reset/busy",      64'(busy),      64'd0);
    check("reset/result",    64'(out_result), 64'd0);
    rst = 1'b1;
    #1 check("reset/in_ready_first", 64'(in_ready), 64'd1);
    @(negedge clk);

    run_op("alu_pass", 1'b0, 3'd0, 32'h11, 32'h22, 32'h1234, 5'd5, 1'b1);
    run_op("mulh_m1x2",  1'b1, 3'd1, 32'hFFFF_FFFF, 32'h2, 32'h0, 5'd1, 1'b1);
    run_op("mulhu_m1x2", 1'b1, 3'd3, 32'hFFFF_FFFF, 32'h2, 32'h0, 5'd2, 1'b1);
    run_op("div_zero",   1'b1, 3'd4, 32'h7, 32'h0, 32'h0, 5'd3, 1'b1);
    run_op("rem_zero",   1'b1, 3'd6, 32'h7, 32'h0, 32'h0, 5'd4, 1'b0);
    run_op("div_ovf",    1'b1, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 5'd6, 1'b1);
    run_op("rem_ovf",    1'b1, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 5'd7, 1'b1);
    run_op("div_m7_2",   1'b1, 3'd4, 32'hFFFF_FFF9, 32'h2, 32'h0, 5'd8, 1'b1);
    run_op("rem_m7_2",   1'b1, 3'd6, 32'hFFFF_FFF9, 32'h2, 32'h0, 5'd9, 1'b1);
    run_op("mulhsu_neg", 1'b1, 3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 5'd10, 1'b1);

    // Backpressure then back-to-back accept on the release cycle.
    hold_exp  = ref_md(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
    out_ready = 1'b0;
    drive(1'b1, 3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 5'd11, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < XLEN + 10) begin @(negedge clk); guard++; end
    check("bp/reached_done", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp/hold_valid",  64'(out_valid),  64'd1);
      check("bp/hold_result", 64'(out_result), 64'(hold_exp));
      check("bp/hold_ready",  64'(in_ready),   64'd0);
      @(negedge clk);
    end
    drive(1'b0, 3'd0, 32'h0, 32'h0, 32'hBEEF, 5'd12, 1'b0);
    out_ready = 1'b1;
    #1 check("b2b/in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("b2b/valid",  64'(out_valid),  64'd1);
    check("b2b/result", 64'(out_result), 64'hBEEF);
    check("b2b/rd",     64'(out_rd),     64'd12);
    @(negedge clk);
    @(negedge clk);
    check("b2b/released", 64'(out_valid), 64'd0);

    // Flush on the 10th BUSY cycle of a DIV.
    drive(1'b1, 3'd4, 32'd1000, 32'd7, 32'h0, 5'd13, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    repeat (9) @(negedge clk);
    check("flush/busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush/busy",     64'(busy),      64'd0);
    check("flush/valid",    64'(out_valid), 64'd0);
    check("flush/in_ready", 64'(in_ready),  64'd1);
    watch_no_valid("flush");
    run_op("after_flush", 1'b1, 3'd4, 32'd1000, 32'd7, 32'h0, 5'd14, 1'b1);

    // Reset pulse in the middle of a MUL.
    drive(1'b1, 3'd0, 32'd123, 32'd456, 32'h0, 5'd15, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid/busy",   64'(busy),       64'd0);
    check("rst_mid/valid",  64'(out_valid),  64'd0);
    check("rst_mid/result", 64'(out_result), 64'd0);
    check("rst_mid/rd",     64'(out_rd),     64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("rst_mid/in_ready", 64'(in_ready), 64'd1);
    watch_no_valid("rst_mid");
    run_op("after_rst", 1'b1, 3'd0, 32'd123, 32'd456, 32'h0, 5'd16, 1'b1);

    for (int i = 0; i < 48; i++) begin
      run_op("random", ($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)),
             rand_operand(), rand_operand(), $urandom,
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
